izh_spike_decoder: RTL
======================

# izh_spike_decoder

Receive-side companion to the Izhikevich neuron core. It consumes the neuron's 8-bit signed membrane-voltage stream, one sample per enabled clock, and detects spikes with a hysteretic two-state detector. Each spike is timestamped as an inter-spike interval (ISI) and queued as an event behind a valid/ready handshake. A windowed spike-rate count is also produced. It sits on the output side of the neuron, directly fed by the membrane-voltage bus (voltage bits [17:10] of the 2.16 state, so 1 LSB = 1/64).

## Interface
- TH_HI, 8'sd19: spike threshold; a sample strictly greater than it is a spike. Matches the neuron's 0.3 peak level.
- TH_LO, -8'sd16: re-arm level; a sample less than or equal to it re-arms the detector. The neuron reset level c = -0.5 maps to -32.
- ISI_W, 16: ISI counter and event width.
- WIN_CYCLES, 1024: rate window length in enabled cycles (≥2).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  sample-enable; high = v_in is a valid sample this cycle.
- v_in  in  8  signed membrane voltage sample.
- spike_pulse  out  1  one-cycle pulse per detected spike.
- evt_valid  out  1  event FIFO non-empty.
- evt_ready  in  1  consumer accepts head event.
- evt_isi  out  ISI_W  head event ISI (enabled cycles since the previous spike).
- evt_first  out  1  head event is the first spike since reset; its ISI counts from reset.
- evt_sat  out  1  head event ISI saturated at all-ones.
- rate  out  8  spikes in last completed window, saturating at 255.
- rate_valid  out  1  one-cycle pulse when rate updates.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.

## Operation
- Detector FSM, states ARMED and FIRED; it advances only when ena=1.
  - ARMED: if v_in > TH_HI (signed compare), detect a spike and go to FIRED. Otherwise stay.
  - FIRED: if v_in ≤ TH_LO, go to ARMED. Otherwise stay; no new spike can be detected while in FIRED.
- ISI counter isi_cnt, ISI_W bits, reset 0. Per enabled cycle:
  - No spike: isi_cnt <= min(isi_cnt+1, all-ones).
  - Spike: the event ISI is min(isi_cnt+1, all-ones), and isi_cnt <= 0.
  - Net effect: spikes detected at enabled cycles t1 and t2 report ISI = t2−t1.
- evt_sat is set when the reported ISI equals all-ones.
- first_flag resets to 1 and clears on the first spike. That event carries evt_first=1.
- Event FIFO, 2 entries, each entry {isi, first, sat}.
  - A push happens on each spike; a pop happens when evt_valid & evt_ready.
  - Full and push without pop: the event is dropped and overflow is set. overflow clears only on reset.
  - Full with push and pop in the same cycle: both happen, so no drop.
  - Empty with push: evt_valid rises next cycle. The FIFO has no bypass.
  - evt_* outputs are stable while evt_valid=1 and evt_ready=0.
- Rate window:
  - win_cnt counts enabled cycles 0..WIN_CYCLES−1. spk_cnt counts spikes, saturating at 255.
  - On the enabled cycle where win_cnt = WIN_CYCLES−1:
    - rate <= spk_cnt plus that cycle's spike, saturating at 255.
    - rate_valid pulses.
    - spk_cnt <= 0 and win_cnt <= 0.
- ena=0 freezes: FSM, isi_cnt, win_cnt, spk_cnt all hold, and spike_pulse stays 0. FIFO pops still proceed.

## Timing
- All outputs are registered.
- A spike sample present with ena at edge k gives the following after edge k:
  - spike_pulse=1 for exactly one cycle.
  - the event written; evt_valid=1 if the FIFO was empty.
- rate/rate_valid update at the edge that closes the window.
- Reset values:
  - FSM: ARMED.
  - Counters and the FIFO: 0 / empty.
  - evt_valid, spike_pulse, rate_valid, overflow: 0.
  - rate: 0.
  - evt_isi, evt_first, evt_sat: 0.
  - first_flag: 1.
- Reset asserted mid-operation takes effect immediately and asynchronously. Queued events are discarded.
- Throughput: at most one spike per 2 enabled cycles, because a spike needs ARMED → FIRED → ARMED.

## Test plan
- Reset, then 10 cycles of v_in=-45, then v_in=25, then v_in=-32 -> spike_pulse after the 25 sample; event {isi=11, first=1, sat=0}; rate stays 0.
- Periodic waveform: peak 25 every 40 enabled cycles, otherwise -40, evt_ready=1 -> from the 2nd event on, each event has isi=40 and first=0; with WIN_CYCLES=1024, rate=25 or 26.
- Hysteresis: 25, 10, 22, -10, 30 (never ≤ -16 after the first peak) -> exactly one spike; a following -20 then 25 -> second spike.
- Backpressure: evt_ready=0, three spikes -> evt_valid=1, head ISI held, overflow=1 after the third spike; then evt_ready=1 -> two events drain in order.
- Saturation with ISI_W=4: 20 quiet cycles then a spike -> isi=15, sat=1.
- ena low for 50 cycles between spikes spaced 10 enabled cycles apart -> isi=10; assert rst_n=0 with events queued -> evt_valid drops immediately and the next event has first=1.

Source files
------------

// File: rtl/izh_spike_decoder_if.sv
// Bus between the membrane-voltage source/event consumer and the spike decoder.
// master: drives samples and accepts events. slave: the decoder.
interface izh_spike_decoder_if #(
    parameter int unsigned ISI_W = 16
) ();
    logic              ena;
    logic signed [7:0] v_in;
    logic              spike_pulse;
    logic              evt_valid;
    logic              evt_ready;
    logic [ISI_W-1:0]  evt_isi;
    logic              evt_first;
    logic              evt_sat;
    logic [7:0]        rate;
    logic              rate_valid;
    logic              overflow;

    modport master (
        output ena, v_in, evt_ready,
        input  spike_pulse, evt_valid, evt_isi, evt_first, evt_sat, rate, rate_valid, overflow
    );

    modport slave (
        input  ena, v_in, evt_ready,
        output spike_pulse, evt_valid, evt_isi, evt_first, evt_sat, rate, rate_valid, overflow
    );
endinterface

// File: rtl/izh_spike_decoder.sv
// Hysteretic spike detector on the neuron's membrane-voltage stream, with
// ISI-timestamped event FIFO (2 deep) and windowed spike-rate counter.
module izh_spike_decoder #(
    parameter logic signed [7:0] TH_HI      = 8'sd19,
    parameter logic signed [7:0] TH_LO      = -8'sd16,
    parameter int unsigned       ISI_W      = 16,
    parameter int unsigned       WIN_CYCLES = 1024
) (
    input logic               clk,
    input logic               rst_n,
    izh_spike_decoder_if.slave bus
);
    localparam int unsigned      WIN_W    = (WIN_CYCLES > 2) ? $clog2(WIN_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);
    localparam logic [ISI_W-1:0] ISI_MAX  = '1;

    typedef struct packed {
        logic [ISI_W-1:0] isi;
        logic             first;
        logic             sat;
    } evt_t;

    typedef enum logic {ARMED = 1'b0, FIRED = 1'b1} state_t;

    state_t           state;
    logic [ISI_W-1:0] isi_cnt;
    logic             first_flag;
    logic             spike_pulse_q;
    evt_t             head;
    evt_t             tail;
    logic             head_vld;
    logic             tail_vld;
    logic             overflow_q;
    logic [WIN_W-1:0] win_cnt;
    logic [7:0]       spk_cnt;
    logic [7:0]       rate_q;
    logic             rate_valid_q;

    logic             spike_c;
    logic             pop_c;
    logic [ISI_W-1:0] isi_inc_c;
    evt_t             new_evt_c;
    logic [7:0]       spk_sum_c;

    // Spike detect, saturating ISI increment and next event payload.
    always_comb begin
        spike_c         = bus.ena && (state == ARMED) && (bus.v_in > TH_HI);
        isi_inc_c       = (isi_cnt == ISI_MAX) ? ISI_MAX : isi_cnt + ISI_W'(1);
        new_evt_c.isi   = isi_inc_c;
        new_evt_c.first = first_flag;
        new_evt_c.sat   = (isi_inc_c == ISI_MAX);
        pop_c           = head_vld && bus.evt_ready;
        spk_sum_c       = (spk_cnt == 8'hFF || !spike_c) ? spk_cnt : spk_cnt + 8'd1;
    end

    // Detector FSM and ISI counter; both frozen while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ARMED;
            isi_cnt       <= '0;
            first_flag    <= 1'b1;
            spike_pulse_q <= 1'b0;
        end else begin
            spike_pulse_q <= spike_c;
            if (bus.ena) begin
                if (state == ARMED) begin
                    if (spike_c) state <= FIRED;
                end else if (bus.v_in <= TH_LO) begin
                    state <= ARMED;
                end
                isi_cnt <= spike_c ? '0 : isi_inc_c;
                if (spike_c) first_flag <= 1'b0;
            end
        end
    end

    // Two-entry FIFO as head/tail registers; head drives the event outputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head       <= '0;
            tail       <= '0;
            head_vld   <= 1'b0;
            tail_vld   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (pop_c) begin
                if (tail_vld) begin
                    head     <= tail;
                    tail_vld <= 1'b0;
                end else begin
                    head_vld <= 1'b0;
                end
            end
            if (spike_c) begin
                if (pop_c) begin
                    if (tail_vld) begin
                        tail     <= new_evt_c;
                        tail_vld <= 1'b1;
                    end else begin
                        head     <= new_evt_c;
                        head_vld <= 1'b1;
                    end
                end else if (!head_vld) begin
                    head     <= new_evt_c;
                    head_vld <= 1'b1;
                end else if (!tail_vld) begin
                    tail     <= new_evt_c;
                    tail_vld <= 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    // Rate window: the closing cycle's own spike is included in the reported count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt      <= '0;
            spk_cnt      <= '0;
            rate_q       <= '0;
            rate_valid_q <= 1'b0;
        end else begin
            rate_valid_q <= 1'b0;
            if (bus.ena) begin
                if (win_cnt == WIN_LAST) begin
                    rate_q       <= spk_sum_c;
                    rate_valid_q <= 1'b1;
                    spk_cnt      <= '0;
                    win_cnt      <= '0;
                end else begin
                    win_cnt <= win_cnt + WIN_W'(1);
                    spk_cnt <= spk_sum_c;
                end
            end
        end
    end

    assign bus.spike_pulse = spike_pulse_q;
    assign bus.evt_valid   = head_vld;
    assign bus.evt_isi     = head.isi;
    assign bus.evt_first   = head.first;
    assign bus.evt_sat     = head.sat;
    assign bus.rate        = rate_q;
    assign bus.rate_valid  = rate_valid_q;
    assign bus.overflow    = overflow_q;
endmodule
